// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared clock-supervision types, saturation limit and helpers
package clk_pkg;

  typedef enum logic [1:0] {
    RST_DCM   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [7:0] CNT_SAT = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - two-flop single-bit synchronizer with selectable reset value
module sync_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// rtl/dcm_lock_supervisor.sv - DCM reset/lock sequencer with retry and loss counters
module dcm_lock_supervisor #(
  parameter int DCM_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RST,
  input  logic       LOCKED,
  output logic       DCM_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic [7:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT,
  input  logic       CLR_CNT
);
  import clk_pkg::*;

  localparam int MAX_A = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LOAD     = CW'(DCM_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lk counts toward the stable window.
  localparam logic [CW-1:0] STABLE_LOAD  = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] ONE          = CW'(1);

  logic lk;

  sync_bit #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (BUS_CLK),
    .rst (BUS_RST),
    .d   (LOCKED),
    .q   (lk)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          dcm_rst_q, dcm_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          retry_inc, loss_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state_q)
      RST_DCM: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABILIZE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d   = RST_DCM;
          cnt_d     = RST_LOAD;
          retry_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      STABILIZE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RUN: begin
        if (!lk) begin
          state_d  = RST_DCM;
          cnt_d    = RST_LOAD;
          loss_inc = 1'b1;
        end
      end
      default: begin
        state_d = RST_DCM;
        cnt_d   = RST_LOAD;
      end
    endcase

    // Clear wins over a coincident increment.
    retry_d = CLR_CNT ? 8'd0 : (retry_inc ? sat_inc(retry_q) : retry_q);
    loss_d  = CLR_CNT ? 8'd0 : (loss_inc ? sat_inc(loss_q) : loss_q);

    dcm_rst_d = (state_d == RST_DCM);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q   <= RST_DCM;
      cnt_q     <= RST_LOAD;
      retry_q   <= 8'd0;
      loss_q    <= 8'd0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      dcm_rst_q <= dcm_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign DCM_RST   = dcm_rst_q;
  assign SYS_RST   = sys_rst_q;
  assign READY     = ready_q;
  assign RETRY_CNT = retry_q;
  assign LOSS_CNT  = loss_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// tb/tb_dcm_lock_supervisor.sv - self-checking bench for dcm_lock_supervisor
module tb_dcm_lock_supervisor;

  localparam int F_RST     = 8;
  localparam int F_TIMEOUT = 64;
  localparam int F_STABLE  = 4;

  logic       clk;
  logic       bus_rst, locked, clr_cnt;
  logic       dcm_rst, sys_rst, ready;
  logic [7:0] retry_cnt, loss_cnt;
  logic       f_rst, f_locked, f_clr;
  logic       f_dcm, f_sys, f_ready;
  logic [7:0] f_retry, f_loss;

  int checks = 0;
  int errors = 0;

  dcm_lock_supervisor #(.DCM_RST_CYCLES(8), .LOCK_TIMEOUT(64), .STABLE_CYCLES(1024)) u_dut (
    .BUS_CLK(clk), .BUS_RST(bus_rst), .LOCKED(locked), .DCM_RST(dcm_rst), .SYS_RST(sys_rst),
    .READY(ready), .RETRY_CNT(retry_cnt), .LOSS_CNT(loss_cnt), .CLR_CNT(clr_cnt)
  );

  dcm_lock_supervisor #(.DCM_RST_CYCLES(F_RST), .LOCK_TIMEOUT(F_TIMEOUT), .STABLE_CYCLES(F_STABLE)) u_fast (
    .BUS_CLK(clk), .BUS_RST(f_rst), .LOCKED(f_locked), .DCM_RST(f_dcm), .SYS_RST(f_sys),
    .READY(f_ready), .RETRY_CNT(f_retry), .LOSS_CNT(f_loss), .CLR_CNT(f_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       lock;
    logic       clr;
    int         cycles;
    logic       dcm;
    logic       sys;
    logic       rdy;
    logic [7:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t vt[12];

  // Reference: phases by name, time spent in phase counted upward, lk seen two edges late.
  int   m_mode, m_elapsed, m_retry, m_loss;
  logic m_p1, m_p2;

  task automatic model_step(input logic rst, input logic lock, input logic clr);
    logic lkv, r_inc, l_inc;
    r_inc = 1'b0;
    l_inc = 1'b0;
    if (rst) begin
      m_mode = 0; m_elapsed = 0; m_retry = 0; m_loss = 0; m_p1 = 1'b0; m_p2 = 1'b0;
      return;
    end
    lkv  = m_p2;
    m_p2 = m_p1;
    m_p1 = lock;
    case (m_mode)
      0: begin
        m_elapsed++;
        if (m_elapsed == F_RST) begin m_mode = 1; m_elapsed = 0; end
      end
      1: begin
        if (lkv) begin m_mode = 2; m_elapsed = 1; end
        else begin
          m_elapsed++;
          if (m_elapsed == F_TIMEOUT) begin m_mode = 0; m_elapsed = 0; r_inc = 1'b1; end
        end
      end
      2: begin
        if (!lkv) begin m_mode = 1; m_elapsed = 0; end
        else begin
          m_elapsed++;
          if (m_elapsed == F_STABLE) m_mode = 3;
        end
      end
      default: begin
        if (!lkv) begin m_mode = 0; m_elapsed = 0; l_inc = 1'b1; end
      end
    endcase
    if (clr) begin m_retry = 0; m_loss = 0; end
    else begin
      if (r_inc && m_retry < 255) m_retry++;
      if (l_inc && m_loss < 255) m_loss++;
    end
  endtask

  initial begin
    int   high_cnt, k, w, t, nrise, first_k, loss_at, pulse_hi, sys_bad, early, tmo;
    int   rise_t[4];
    logic [7:0] rise_retry[4];
    logic prev;
    logic [18:0] exp_v, act_v;

    bus_rst = 1'b1; locked = 1'b0; clr_cnt = 1'b0;
    f_rst = 1'b1; f_locked = 1'b0; f_clr = 1'b0;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 7,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 8'd0, 8'd1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b1, 1'b0, 8'd0, 8'd1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 63, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 8'd1, 8'd1};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 8'd0, 8'd0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      f_rst = vt[i].rst; f_locked = vt[i].lock; f_clr = vt[i].clr;
      repeat (vt[i].cycles) @(negedge clk);
      exp_v = {vt[i].dcm, vt[i].sys, vt[i].rdy, vt[i].retry, vt[i].loss};
      act_v = {f_dcm, f_sys, f_ready, f_retry, f_loss};
      check($sformatf("vec[%0d]", i), 32'(act_v), 32'(exp_v));
    end
    f_clr = 1'b0;

    // Reset state and release timing on the full-size instance.
    repeat (5) @(negedge clk);
    check("rst_state", {27'd0, dcm_rst, sys_rst, ready, 2'b00}, {27'd0, 3'b110, 2'b00});
    check("rst_counters", {16'd0, retry_cnt, loss_cnt}, 32'd0);
    bus_rst  = 1'b0;
    high_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (dcm_rst) high_cnt++;
      @(negedge clk);
    end
    if (dcm_rst) high_cnt++;
    locked = 1'b1;
    k = 0;
    while (!ready && k < 1200) begin
      @(negedge clk);
      k++;
      if (dcm_rst) high_cnt++;
    end
    check("dcm_pulse_len", high_cnt, 8);
    check_range("ready_latency", k, 1025, 1027);
    check("sys_rst_in_run", {31'd0, sys_rst}, 32'd0);
    check("retry_after_lock", {24'd0, retry_cnt}, 32'd0);

    // Loss in RUN, then LOCKED held low through three timeouts.
    locked = 1'b0;
    prev = dcm_rst; nrise = 0; first_k = -1; loss_at = -1; pulse_hi = 0; sys_bad = 0;
    for (t = 1; t <= 400 && nrise < 4; t++) begin
      @(negedge clk);
      if (first_k < 0 && sys_rst && !ready) begin first_k = t; loss_at = loss_cnt; end
      if (dcm_rst && !prev) begin
        rise_t[nrise] = t; rise_retry[nrise] = retry_cnt; nrise++;
      end
      if (dcm_rst && nrise == 1) pulse_hi++;
      if (first_k >= 0 && !sys_rst) sys_bad++;
      prev = dcm_rst;
    end
    check_range("loss_reaction", first_k, 1, 3);
    check("loss_cnt_1", loss_at, 1);
    check("loss_pulse_len", pulse_hi, 8);
    check("rise_count", nrise, 4);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("retry_period[%0d]", i), rise_t[i] - rise_t[i-1], 72);
      check($sformatf("retry_cnt[%0d]", i), {24'd0, rise_retry[i]}, i);
    end
    check("sys_rst_held", sys_bad, 0);

    // One-cycle glitch part-way through the stable window.
    w = 0;
    while (dcm_rst && w < 20) begin @(negedge clk); w++; end
    locked = 1'b1;
    early = 0;
    repeat (502) begin @(negedge clk); if (ready) early++; end
    locked = 1'b0;
    @(negedge clk);
    if (ready) early++;
    locked = 1'b1;
    k = 0;
    while (!ready && k < 1200) begin @(negedge clk); k++; end
    check("glitch_no_early_ready", early, 0);
    check_range("glitch_ready_latency", k, 1025, 1027);
    check("glitch_counters", {16'd0, retry_cnt, loss_cnt}, {16'd0, 8'd3, 8'd1});

    // Bus reset while running.
    bus_rst = 1'b1;
    @(negedge clk);
    check("busrst_outputs", {29'd0, dcm_rst, sys_rst, ready}, {29'd0, 3'b110});
    check("busrst_counters", {16'd0, retry_cnt, loss_cnt}, 32'd0);

    // Saturate the loss counter, then clear coincident with a loss.
    f_rst = 1'b0; f_locked = 1'b1;
    tmo = 0;
    for (int n = 0; n < 300; n++) begin
      w = 0;
      while (!f_ready && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) tmo++;
      f_locked = 1'b0;
      w = 0;
      while (!f_dcm && w < 20) begin @(negedge clk); w++; end
      if (w >= 20) tmo++;
      f_locked = 1'b1;
    end
    check("loss_loop_timeouts", tmo, 0);
    check("loss_saturated", {24'd0, f_loss}, 32'd255);
    check("retry_unchanged", {24'd0, f_retry}, 32'd0);
    w = 0;
    while (!f_ready && w < 200) begin @(negedge clk); w++; end
    f_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    f_clr = 1'b1;
    @(negedge clk);
    f_clr = 1'b0;
    check("clr_vs_loss", {24'd0, f_loss}, 32'd0);
    check("clr_loss_event", {31'd0, f_dcm}, 32'd1);

    // Randomized run against the reference model.
    f_locked = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      f_rst = (c < 2) || ($urandom_range(599) == 0);
      if (f_locked) begin
        if ($urandom_range(39) == 0) f_locked = 1'b0;
      end else begin
        if ($urandom_range(39) == 0) f_locked = 1'b1;
      end
      f_clr = ($urandom_range(63) == 0);
      model_step(f_rst, f_locked, f_clr);
      @(posedge clk);
      #1;
      exp_v = {m_mode == 0, m_mode != 3, m_mode == 3, 8'(m_retry), 8'(m_loss)};
      act_v = {f_dcm, f_sys, f_ready, f_retry, f_loss};
      check($sformatf("rand[%0d]", c), 32'(act_v), 32'(exp_v));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcm_lock_supervisor.md
DCM_LOCK_SUPERVISOR -- requirements
Module: dcm_lock_supervisor

Interface
REQ-001 SHALL have parameter DCM_RST_CYCLES, default 8: cycles DCM_RST is held high per reset attempt (range 3..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed for lock before a retry (range 16..2^20).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: cycles LOCKED must stay high before release (range 2..2^16).
REQ-004 SHALL have port BUS_CLK, input, 1: sole clock.
REQ-005 SHALL have port BUS_RST, input, 1: reset, synchronous to BUS_CLK, active-high.
REQ-006 SHALL have port LOCKED, input, 1: DCM lock status, asynchronous to BUS_CLK.
REQ-007 SHALL have port DCM_RST, output, 1: reset to the downstream DCM RST pin.
REQ-008 SHALL have port SYS_RST, output, 1: reset for logic on the generated clocks.
REQ-009 SHALL have port READY, output, 1: clocks locked and stable.
REQ-010 SHALL have port RETRY_CNT, output, 8: lock-timeout retries (saturating).
REQ-011 SHALL have port LOSS_CNT, output, 8: lock losses seen in RUN (saturating).
REQ-012 SHALL have port CLR_CNT, input, 1: single-cycle pulse that clears RETRY_CNT and LOSS_CNT.

Function
REQ-013 SHALL pass LOCKED through a 2-flop synchronizer; all logic uses only the synchronized value lk.
REQ-014 SHALL implement FSM states RST_DCM, WAIT_LOCK, STABILIZE and RUN, driven by a single shared down-counter.
REQ-015 SHALL, in RST_DCM, hold DCM_RST=1 for exactly DCM_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-016 SHALL, in WAIT_LOCK: on lk=1, go to STABILIZE.
REQ-017 SHALL, in WAIT_LOCK: after LOCK_TIMEOUT cycles without lk, go to RST_DCM and increment RETRY_CNT.
REQ-018 SHALL, in STABILIZE: after lk=1 for STABLE_CYCLES consecutive cycles, go to RUN.
REQ-019 SHALL, in STABILIZE: any lk=0 returns to WAIT_LOCK and restarts the timeout; no counter increments.
REQ-020 SHALL, in RUN: on lk=0, go to RST_DCM on the next cycle and increment LOSS_CNT.
REQ-021 SHALL assert SYS_RST=1 in every state except RUN.
REQ-022 SHALL deassert SYS_RST and assert READY registered, on the first cycle in RUN.
REQ-023 SHALL reassert SYS_RST and deassert READY in the cycle the FSM leaves RUN.
REQ-024 SHALL saturate both counters at 255, with no wrap.
REQ-025 SHALL, when CLR_CNT and an increment occur in the same cycle, give priority to the clear (result 0).
REQ-026 SHALL drive all outputs from registers; no combinational path from input to output.
REQ-027 SHALL size counter widths with $clog2 of the largest parameter.

Reset
REQ-028 SHALL, on BUS_RST=1 (synchronous), enter RST_DCM.
REQ-029 SHALL, while BUS_RST=1, drive DCM_RST=1, SYS_RST=1, READY=0, RETRY_CNT=0 and LOSS_CNT=0, with synchronizer flops at 0.
REQ-030 SHALL, when BUS_RST is asserted mid-operation (any state), abort the state immediately.
REQ-031 SHALL, after BUS_RST release, perform a full DCM_RST_CYCLES pulse counted from the release.

Structure
REQ-032 SHALL place the state encoding (RST_DCM=0, WAIT_LOCK=1, STABILIZE=2, RUN=3) and the counter saturation value in shared package clk_pkg.
REQ-033 SHALL instantiate one sub-module, sync_bit (2-flop synchronizer, parameterizable reset value), which is reused elsewhere for CDC.

Verification
REQ-034 SHALL verify: BUS_RST release, LOCKED rising 20 cycles later -> DCM_RST high exactly 8 cycles; READY=1 at 2 (sync) + 1024 cycles after LOCKED rise, ±1.
REQ-035 SHALL verify: LOCKED held 0 with TIMEOUT=64 -> DCM_RST re-pulses every 8+64 cycles; RETRY_CNT increments 1,2,3; SYS_RST stays 1 throughout.
REQ-036 SHALL verify: LOCKED glitches low for 1 cycle at STABLE count 500 -> back to WAIT_LOCK; READY only 1024 cycles after the glitch; RETRY_CNT and LOSS_CNT unchanged.
REQ-037 SHALL verify: LOCKED drops in RUN -> SYS_RST=1 and READY=0 within 3 cycles of the drop; LOSS_CNT=1; new 8-cycle DCM_RST pulse.
REQ-038 SHALL verify: force 300 losses -> LOSS_CNT=255; CLR_CNT coincident with a loss -> LOSS_CNT=0.
REQ-039 SHALL verify: BUS_RST pulsed while in RUN -> next cycle READY=0 and DCM_RST=1; counters=0.
